mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
// The owner tag records which port the in-flight read response belongs to.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_D    = 2'd2
    } own_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals between the pipeline ports,
// the arbiter and the shared single-port memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);
    logic              i_f_valid;
    logic [ADDR_W-1:0] i_f_addr;
    logic              o_f_ready;
    logic              o_f_rvalid;
    logic [DATA_W-1:0] o_f_rdata;

    logic              i_d_valid;
    logic              i_d_we;
    logic [ADDR_W-1:0] i_d_addr;
    logic [DATA_W-1:0] i_d_wdata;
    logic              o_d_ready;
    logic              o_d_rvalid;
    logic [DATA_W-1:0] o_d_rdata;

    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              o_mem_read;
    logic              o_mem_write;
    logic [DATA_W-1:0] i_mem_rdata;

    // Arbiter side.
    modport slave (
        input  i_f_valid, i_f_addr, i_d_valid, i_d_we, i_d_addr, i_d_wdata, i_mem_rdata,
        output o_f_ready, o_f_rvalid, o_f_rdata, o_d_ready, o_d_rvalid, o_d_rdata,
        output o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write
    );

    // Requester and memory side.
    modport master (
        output i_f_valid, i_f_addr, i_d_valid, i_d_we, i_d_addr, i_d_wdata, i_mem_rdata,
        input  o_f_ready, o_f_rvalid, o_f_rdata, o_d_ready, o_d_rvalid, o_d_rdata,
        input  o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one registered-read memory between instruction fetch and data access.
// Data has fixed priority; fetch is forced through after STARVE_MAX denied cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    mem_arbiter_if.slave  bus
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  r_starve_cnt;
    own_t              r_own;
    logic [DATA_W-1:0] r_f_hold;
    logic [DATA_W-1:0] r_d_hold;

    logic              w_force_f;
    logic              w_grant_f;
    logic              w_grant_d;
    own_t              w_own_next;

    assign w_force_f = bus.i_f_valid && (r_starve_cnt == MAX_CNT);
    assign w_grant_d = bus.i_d_valid && !w_force_f;
    assign w_grant_f = bus.i_f_valid && !w_grant_d;

    assign bus.o_f_ready = w_grant_f;
    assign bus.o_d_ready = w_grant_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the branches can leave it unassigned and infer a latch.
    always_comb begin
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_read  = 1'b0;
        bus.o_mem_write = 1'b0;
        w_own_next      = OWN_NONE;
        if (w_grant_d) begin
            bus.o_mem_addr = bus.i_d_addr;
            if (bus.i_d_we) begin
                bus.o_mem_wdata = bus.i_d_wdata;
                bus.o_mem_write = 1'b1;
            end else begin
                bus.o_mem_read = 1'b1;
                w_own_next     = OWN_D;
            end
        end else if (w_grant_f) begin
            bus.o_mem_addr = bus.i_f_addr;
            bus.o_mem_read = 1'b1;
            w_own_next     = OWN_F;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_own <= OWN_NONE;
        end else begin
            r_own <= w_own_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant_f || !bus.i_f_valid) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != MAX_CNT) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Hold registers keep the last response visible to a stalled stage.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_f_hold <= '0;
            r_d_hold <= '0;
        end else begin
            if (r_own == OWN_F) r_f_hold <= bus.i_mem_rdata;
            if (r_own == OWN_D) r_d_hold <= bus.i_mem_rdata;
        end
    end

    assign bus.o_f_rvalid = (r_own == OWN_F);
    assign bus.o_d_rvalid = (r_own == OWN_D);
    assign bus.o_f_rdata  = (r_own == OWN_F) ? bus.i_mem_rdata : r_f_hold;
    assign bus.o_d_rdata  = (r_own == OWN_D) ? bus.i_mem_rdata : r_d_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, scoreboard of
// expected read responses, starvation patterns for STARVE_MAX=4 and 1.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus  ();
    mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(1)) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory behind the arbiter: registered read, write visible next cycle.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin
        if (bus.o_mem_write) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
        if (bus.o_mem_read)  bus.i_mem_rdata     <= mem[bus.o_mem_addr];
    end

    // Scoreboard: expected read data queued on acceptance, checked next cycle.
    logic [31:0] f_q[$];
    logic [31:0] d_q[$];
    logic        f_pend = 1'b0;
    logic        d_pend = 1'b0;
    logic [31:0] f_hold_m = '0;
    logic [31:0] d_hold_m = '0;

    always @(posedge rst) begin
        f_q.delete();
        d_q.delete();
        f_pend   = 1'b0;
        d_pend   = 1'b0;
        f_hold_m = '0;
        d_hold_m = '0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [31:0] exp;
            check("f_rvalid", {31'd0, bus.o_f_rvalid}, {31'd0, f_pend});
            check("d_rvalid", {31'd0, bus.o_d_rvalid}, {31'd0, d_pend});
            if (f_pend && f_q.size() > 0) begin
                exp = f_q.pop_front();
                check("f_rdata", bus.o_f_rdata, exp);
                f_hold_m = exp;
            end else begin
                check("f_hold", bus.o_f_rdata, f_hold_m);
            end
            if (d_pend && d_q.size() > 0) begin
                exp = d_q.pop_front();
                check("d_rdata", bus.o_d_rdata, exp);
                d_hold_m = exp;
            end else begin
                check("d_hold", bus.o_d_rdata, d_hold_m);
            end
            f_pend = 1'b0;
            d_pend = 1'b0;
            if (bus.i_f_valid && bus.o_f_ready) begin
                f_q.push_back(ref_mem[bus.i_f_addr]);
                f_pend = 1'b1;
            end
            if (bus.i_d_valid && bus.o_d_ready) begin
                if (bus.i_d_we) begin
                    ref_mem[bus.i_d_addr] = bus.i_d_wdata;
                end else begin
                    d_q.push_back(ref_mem[bus.i_d_addr]);
                    d_pend = 1'b1;
                end
            end
        end
    end

    task automatic drive(input logic fv, input logic [7:0] fa, input logic dv,
                         input logic dwe, input logic [7:0] da, input logic [31:0] dwd);
        bus.i_f_valid = fv;
        bus.i_f_addr  = fa;
        bus.i_d_valid = dv;
        bus.i_d_we    = dwe;
        bus.i_d_addr  = da;
        bus.i_d_wdata = dwd;
    endtask

    // Drive one cycle, check both readies before the edge, return at edge+1.
    task automatic cyc(input logic fv, input logic [7:0] fa, input logic dv,
                       input logic dwe, input logic [7:0] da, input logic [31:0] dwd,
                       input logic exp_fr, input logic exp_dr);
        drive(fv, fa, dv, dwe, da, dwd);
        #2;
        check("f_ready", {31'd0, bus.o_f_ready}, {31'd0, exp_fr});
        check("d_ready", {31'd0, bus.o_d_ready}, {31'd0, exp_dr});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 8'h00, 32'h0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[8'h04] = 32'h11;        ref_mem[8'h04] = 32'h11;
        mem[8'h08] = 32'h22;        ref_mem[8'h08] = 32'h22;
        mem[8'h20] = 32'hAAAA5555;  ref_mem[8'h20] = 32'hAAAA5555;
        bus.i_mem_rdata  = '0;
        bus1.i_mem_rdata = '0;
        drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
        bus1.i_f_valid = 1'b0;  bus1.i_f_addr = '0;
        bus1.i_d_valid = 1'b0;  bus1.i_d_we   = 1'b0;
        bus1.i_d_addr  = '0;    bus1.i_d_wdata = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        #1;
        check("rst_f_rvalid", {31'd0, bus.o_f_rvalid}, 32'd0);
        check("rst_d_rvalid", {31'd0, bus.o_d_rvalid}, 32'd0);
        check("rst_f_rdata", bus.o_f_rdata, 32'd0);
        check("rst_d_rdata", bus.o_d_rdata, 32'd0);
        check("rst_mem_en", {30'd0, bus.o_mem_read, bus.o_mem_write}, 32'd0);
        check("rst_mem_addr", {24'd0, bus.o_mem_addr}, 32'd0);
        @(posedge clk); #1;
        idle(1);

        // Fetch-only back to back
        cyc(1, 8'h04, 0, 0, 8'h00, 32'h0, 1, 0);
        cyc(1, 8'h08, 0, 0, 8'h00, 32'h0, 1, 0);
        idle(2);

        // Write then read the same address
        drive(0, 8'h00, 1, 1, 8'h10, 32'hDEADBEEF);
        #2;
        check("wr_mem_write", {31'd0, bus.o_mem_write}, 32'd1);
        check("wr_mem_read", {31'd0, bus.o_mem_read}, 32'd0);
        check("wr_mem_addr", {24'd0, bus.o_mem_addr}, 32'h10);
        check("wr_mem_wdata", bus.o_mem_wdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("wr_no_rvalid", {31'd0, bus.o_d_rvalid}, 32'd0);
        cyc(0, 8'h00, 1, 0, 8'h10, 32'h0, 0, 1);
        check("rd_d_rvalid", {31'd0, bus.o_d_rvalid}, 32'd1);
        check("rd_d_rdata", bus.o_d_rdata, 32'hDEADBEEF);
        idle(1);

        // Alternating ports back to back
        cyc(1, 8'h04, 0, 0, 8'h00, 32'h0, 1, 0);
        cyc(0, 8'h00, 1, 0, 8'h08, 32'h0, 0, 1);
        cyc(1, 8'h10, 0, 0, 8'h00, 32'h0, 1, 0);
        cyc(0, 8'h00, 1, 0, 8'h04, 32'h0, 0, 1);
        idle(2);

        // Contention: STARVE_MAX=4 on dut, STARVE_MAX=1 on dut1
        bus1.i_f_valid = 1'b1;
        bus1.i_d_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'h04, 1, 0, 8'h08, 32'h0);
            #2;
            check("st4_f_ready", {31'd0, bus.o_f_ready}, (i % 5 == 4) ? 32'd1 : 32'd0);
            check("st4_d_ready", {31'd0, bus.o_d_ready}, (i % 5 == 4) ? 32'd0 : 32'd1);
            check("st4_cnt_le_max", (int'(dut.r_starve_cnt) <= 4) ? 32'd1 : 32'd0, 32'd1);
            check("st1_f_ready", {31'd0, bus1.o_f_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("st1_d_ready", {31'd0, bus1.o_d_ready}, (i % 2 == 1) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
        end
        bus1.i_f_valid = 1'b0;
        bus1.i_d_valid = 1'b0;
        idle(2);

        // Hold register across idle fetch cycles
        cyc(1, 8'h20, 0, 0, 8'h00, 32'h0, 1, 0);
        check("hold_rvalid", {31'd0, bus.o_f_rvalid}, 32'd1);
        check("hold_rdata0", bus.o_f_rdata, 32'hAAAA5555);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 0, 0, 8'h00, 32'h0, 0, 0);
            check("hold_idle_rvalid", {31'd0, bus.o_f_rvalid}, 32'd0);
            check("hold_idle_rdata", bus.o_f_rdata, 32'hAAAA5555);
        end

        // Reset pulsed while a response is pending
        cyc(1, 8'h08, 0, 0, 8'h00, 32'h0, 1, 0);
        drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rstmid_f_rvalid", {31'd0, bus.o_f_rvalid}, 32'd0);
        check("rstmid_d_rvalid", {31'd0, bus.o_d_rvalid}, 32'd0);
        check("rstmid_f_rdata", bus.o_f_rdata, 32'd0);
        check("rstmid_d_rdata", bus.o_d_rdata, 32'd0);
        @(posedge clk); #1;
        check("rstpost_f_rvalid", {31'd0, bus.o_f_rvalid}, 32'd0);
        check("rstpost_f_rdata", bus.o_f_rdata, 32'd0);
        idle(2);

        check("sb_f_empty", f_q.size(), 32'd0);
        check("sb_d_empty", d_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
